// File: rtl/nla_pkg.sv
// Shared types and defaults for the nonlinear-approximation request scheduler.
package nla_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } nla_state_e;

  localparam int NLA_NUM_REQ = 4;
  localparam int NLA_DATA_W  = 16;
  localparam int NLA_TIMEOUT = 64;
  localparam int NLA_ID_W    = $clog2(NLA_NUM_REQ);

  // Response record at the default geometry.
  typedef struct packed {
    logic [NLA_ID_W-1:0]   id;
    logic [NLA_DATA_W-1:0] data;
    logic                  err;
  } nla_resp_t;

endpackage

// File: rtl/nla_rr_pick.sv
// Combinational rotating-priority picker: first valid index at or above ptr_i,
// wrapping modulo N.
module nla_rr_pick #(
  parameter int  N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin : pick
    logic found;
    int   j;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && valid_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
    any_o = |valid_i;
  end

endmodule

// File: rtl/nla_req_scheduler.sv
// Round-robin front end sharing one nonlinear-approximation engine between
// NUM_REQ requesters, one evaluation in flight, with a watchdog abort.
module nla_req_scheduler
  import nla_pkg::*;
#(
  parameter int  NUM_REQ = NLA_NUM_REQ,
  parameter int  DATA_W  = NLA_DATA_W,
  parameter int  TIMEOUT = NLA_TIMEOUT,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_mode_i,
  output logic                      eng_start_o,
  output logic [DATA_W-1:0]         eng_data_o,
  output logic                      eng_mode_o,
  input  logic                      eng_busy_i,
  input  logic                      eng_done_i,
  input  logic [DATA_W-1:0]         eng_result_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [ID_W-1:0]           resp_id_o,
  output logic [DATA_W-1:0]         resp_data_o,
  output logic                      resp_err_o,
  output logic                      busy_o
);

  localparam int TMR_W = $clog2(TIMEOUT);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_t;

  nla_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic              cap_mode_q, cap_mode_d;
  logic [ID_W-1:0]   cap_id_q, cap_id_d;
  resp_t             resp_q, resp_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  nla_rr_pick #(.N(NUM_REQ)) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    timer_d      = timer_q;
    cap_data_d   = cap_data_q;
    cap_mode_d   = cap_mode_q;
    cap_id_d     = cap_id_q;
    resp_d       = resp_q;
    req_ready_o  = '0;
    eng_start_o  = 1'b0;
    resp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        // No grant while reset is held: the handshake would be lost.
        if (!rst_i && !eng_busy_i && pick_any) begin
          req_ready_o = pick_grant;
          cap_data_d  = req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
          cap_mode_d  = req_mode_i[pick_idx];
          cap_id_d    = pick_idx;
          rr_d        = (pick_idx == ID_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        eng_start_o = 1'b1;
        timer_d     = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // A done arriving on the timeout cycle still counts as success.
        if (eng_done_i) begin
          resp_d  = '{id: cap_id_q, data: eng_result_i, err: 1'b0};
          state_d = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT-1)) begin
          resp_d  = '{id: cap_id_q, data: '0, err: 1'b1};
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      timer_q    <= '0;
      cap_data_q <= '0;
      cap_mode_q <= 1'b0;
      cap_id_q   <= '0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      timer_q    <= timer_d;
      cap_data_q <= cap_data_d;
      cap_mode_q <= cap_mode_d;
      cap_id_q   <= cap_id_d;
      resp_q     <= resp_d;
    end
  end

  assign eng_data_o  = cap_data_q;
  assign eng_mode_o  = cap_mode_q;
  assign resp_id_o   = resp_q.id;
  assign resp_data_o = resp_q.data;
  assign resp_err_o  = resp_q.err;
  assign busy_o      = (state_q != IDLE);

endmodule
